// File: rtl/fft8_pkg.sv
// Shared constants and state encoding for the 8-point radix-2 DIT FFT
// control path. Imported by fft8_addr_gen and fft8_sequencer.
package fft8_pkg;

  localparam int N            = 8;
  localparam int LOG2N        = 3;
  localparam int BF_PER_STAGE = 4;
  localparam int ADDR_W       = $clog2(N);
  localparam int TW_W         = 3;
  localparam int LAST_STAGE   = LOG2N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft8_addr_gen.sv
// Combinational butterfly address/twiddle generator for the 8-point FFT.
// Ports:
//   stage - current stage 0..2
//   j     - butterfly index within the stage 0..3
//   a, b  - upper/lower operand sample addresses
//   k     - twiddle index (W8^k); bit 2 is always 0
module fft8_addr_gen
  import fft8_pkg::*;
(
  input  logic [1:0]        stage,
  input  logic [1:0]        j,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b,
  output logic [TW_W-1:0]   k
);

  // a inserts a 0 at bit position `stage` of j; b sets that bit instead.
  // k is the low `stage` bits of j shifted up to the MSB side of a 2-bit index.
  always_comb begin
    a = '0;
    b = '0;
    k = '0;
    case (stage)
      2'd0: begin
        a = {j, 1'b0};
        b = {j, 1'b1};
      end
      2'd1: begin
        a = {j[1], 1'b0, j[0]};
        b = {j[1], 1'b1, j[0]};
        k = {1'b0, j[0], 1'b0};
      end
      2'd2: begin
        a = {1'b0, j};
        b = {1'b1, j};
        k = {1'b0, j};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fft8_sequencer.sv
// Control sequencer for the 8-point radix-2 DIT FFT: 3 stages of 4
// butterflies, each stage followed by a drain so no stage reads data the
// previous stage has not yet written back.
// Ports:
//   clk, rst_n          - clock (rising edge), async active-low reset
//   start               - run request, sampled only in IDLE
//   busy, done          - high while issuing/draining; one-cycle end pulse
//   rd_en               - operand read strobe (sync-read sample RAM)
//   rd_addr_a/b         - operand addresses, 0 when rd_en=0
//   tw_index            - twiddle ROM index, 0 when rd_en=0
//   bf_valid            - butterfly inputs valid, one cycle after rd_en
//   stage               - current stage 0..2
//   wr_en, wr_addr_a/b  - write-back strobe/addresses, BF_LAT after bf_valid
module fft8_sequencer
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rd_en,
  output logic [2:0] rd_addr_a,
  output logic [2:0] rd_addr_b,
  output logic [2:0] tw_index,
  output logic       bf_valid,
  output logic [1:0] stage,
  output logic       wr_en,
  output logic [2:0] wr_addr_a,
  output logic [2:0] wr_addr_b
);

  localparam logic [2:0] DRAIN_LAST = 3'(BF_LAT);
  localparam logic [1:0] J_LAST     = 2'(BF_PER_STAGE - 1);
  localparam logic [1:0] STAGE_LAST = 2'(LAST_STAGE);

  state_t     state;
  logic [1:0] j;
  logic [2:0] dcnt;

  logic [ADDR_W-1:0] gen_a;
  logic [ADDR_W-1:0] gen_b;
  logic [TW_W-1:0]   gen_k;

  fft8_addr_gen u_addr_gen (
    .stage (stage),
    .j     (j),
    .a     (gen_a),
    .b     (gen_b),
    .k     (gen_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      stage <= '0;
      j     <= '0;
      dcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= ISSUE;
            stage <= '0;
            j     <= '0;
          end
        end
        ISSUE: begin
          if (j == J_LAST) begin
            state <= DRAIN;
            dcnt  <= '0;
            j     <= '0;
          end else begin
            j <= j + 2'd1;
          end
        end
        // 1+BF_LAT cycles: lets the last butterfly of this stage write back
        // before the next stage reads.
        DRAIN: begin
          if (dcnt == DRAIN_LAST) begin
            if (stage == STAGE_LAST) begin
              state <= DONE;
            end else begin
              state <= ISSUE;
              stage <= stage + 2'd1;
            end
          end else begin
            dcnt <= dcnt + 3'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rd_en     = (state == ISSUE);
    busy      = (state == ISSUE) || (state == DRAIN);
    done      = (state == DONE);
    rd_addr_a = rd_en ? gen_a : '0;
    rd_addr_b = rd_en ? gen_b : '0;
    tw_index  = rd_en ? gen_k : '0;
  end

  // Delay line: slot 0 is the bf_valid stage, slot BF_LAT the write-back.
  // Addresses enter already zero-gated, so idle slots carry 0 addresses.
  logic [BF_LAT:0] vpipe;
  logic [2:0]      apipe [BF_LAT:0];
  logic [2:0]      bpipe [BF_LAT:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      for (int unsigned i = 0; i <= BF_LAT; i++) begin
        apipe[i] <= '0;
        bpipe[i] <= '0;
      end
    end else begin
      vpipe[0] <= rd_en;
      apipe[0] <= rd_addr_a;
      bpipe[0] <= rd_addr_b;
      for (int unsigned i = 1; i <= BF_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
        apipe[i] <= apipe[i-1];
        bpipe[i] <= bpipe[i-1];
      end
    end
  end

  always_comb begin
    bf_valid  = vpipe[0];
    wr_en     = vpipe[BF_LAT];
    wr_addr_a = apipe[BF_LAT];
    wr_addr_b = bpipe[BF_LAT];
  end

endmodule

// File: tb/tb_fft8_sequencer.sv
module tb_fft8_sequencer;

  typedef struct packed {
    int         cyc;
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] k;
    logic [1:0] st;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start3;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic mon_on = 1'b0;

  // DUT with BF_LAT=1
  logic       busy1, done1, rd1, bfv1, wr1;
  logic [2:0] ra1, rb1, tw1, wa1, wb1;
  logic [1:0] st1;
  // DUT with BF_LAT=3
  logic       busy3, done3, rd3, bfv3, wr3;
  logic [2:0] ra3, rb3, tw3, wa3, wb3;
  logic [1:0] st3;

  ev_t rq1[$], wq1[$], rq3[$], wq3[$];
  int  bq1[$], dq1[$], bq3[$], dq3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft8_sequencer #(.BF_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd1), .rd_addr_a(ra1), .rd_addr_b(rb1), .tw_index(tw1),
    .bf_valid(bfv1), .stage(st1), .wr_en(wr1), .wr_addr_a(wa1), .wr_addr_b(wb1)
  );

  fft8_sequencer #(.BF_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
    .rd_en(rd3), .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_index(tw3),
    .bf_valid(bfv3), .stage(st3), .wr_en(wr3), .wr_addr_a(wa3), .wr_addr_b(wb3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected transactions of one complete run whose first issue cycle is e.
  task automatic push_run(input int u, input int e);
    int  lat, per, span, rc;
    ev_t ev;
    lat = (u == 1) ? 1 : 3;
    per = 5 + lat;
    for (int s = 0; s < 3; s++) begin
      for (int jj = 0; jj < 4; jj++) begin
        span  = 1 << s;
        rc    = e + s * per + jj;
        ev.a  = 3'(((jj >> s) << (s + 1)) | (jj & (span - 1)));
        ev.b  = 3'(int'(ev.a) + span);
        ev.k  = 3'((jj & (span - 1)) << (2 - s));
        ev.st = 2'(s);
        ev.cyc = rc;
        if (u == 1) begin
          rq1.push_back(ev);
          bq1.push_back(rc + 1);
          ev.cyc = rc + 1 + lat;
          wq1.push_back(ev);
        end else begin
          rq3.push_back(ev);
          bq3.push_back(rc + 1);
          ev.cyc = rc + 1 + lat;
          wq3.push_back(ev);
        end
      end
    end
    if (u == 1) dq1.push_back(e + 3 * per);
    else        dq3.push_back(e + 3 * per);
  endtask

  // Per-cycle directed checks from cycle 1 (caller is #1 after that edge).
  task automatic directed(input int u, input int ncyc);
    int  lat, per;
    logic b, d, r;
    lat = (u == 1) ? 1 : 3;
    per = 5 + lat;
    for (int n = 1; n <= ncyc; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      b = (u == 1) ? busy1 : busy3;
      d = (u == 1) ? done1 : done3;
      r = (u == 1) ? rd1 : rd3;
      chk($sformatf("busy_u%0d_c%0d", u, n), 32'(b), 32'(n <= 3 * per));
      chk($sformatf("done_u%0d_c%0d", u, n), 32'(d), 32'(n == 3 * per + 1));
      chk($sformatf("rden_u%0d_c%0d", u, n), 32'(r),
          32'((n <= 3 * per) && (((n - 1) % per) < 4)));
      if (u == 1 && n == 8) begin
        chk("c8_rd_addr_a", 32'(ra1), 32'd1);
        chk("c8_rd_addr_b", 32'(rb1), 32'd3);
        chk("c8_tw_index", 32'(tw1), 32'd2);
      end
      if (u == 1 && n >= 13 && n <= 16)
        chk($sformatf("s2_tw_c%0d", n), 32'(tw1), 32'(n - 13));
    end
  endtask

  always @(negedge clk) begin : mon1
    ev_t e;
    int  c;
    if (mon_on) begin
      if (rd1) begin
        chk("rd1_expected", 32'(rq1.size() != 0), 32'd1);
        if (rq1.size() != 0) begin
          e = rq1.pop_front();
          chk("rd1_cyc", 32'(cyc), 32'(e.cyc));
          chk("rd1_a", 32'(ra1), 32'(e.a));
          chk("rd1_b", 32'(rb1), 32'(e.b));
          chk("rd1_k", 32'(tw1), 32'(e.k));
          chk("rd1_stage", 32'(st1), 32'(e.st));
        end
      end else chk("rd1_idle_zero", 32'({ra1, rb1, tw1}), 32'd0);
      if (bfv1) begin
        chk("bfv1_expected", 32'(bq1.size() != 0), 32'd1);
        if (bq1.size() != 0) begin
          c = bq1.pop_front();
          chk("bfv1_cyc", 32'(cyc), 32'(c));
        end
      end
      if (wr1) begin
        chk("wr1_expected", 32'(wq1.size() != 0), 32'd1);
        if (wq1.size() != 0) begin
          e = wq1.pop_front();
          chk("wr1_cyc", 32'(cyc), 32'(e.cyc));
          chk("wr1_a", 32'(wa1), 32'(e.a));
          chk("wr1_b", 32'(wb1), 32'(e.b));
        end
      end else chk("wr1_idle_zero", 32'({wa1, wb1}), 32'd0);
      if (done1) begin
        chk("done1_expected", 32'(dq1.size() != 0), 32'd1);
        chk("done1_busy", 32'(busy1), 32'd0);
        if (dq1.size() != 0) begin
          c = dq1.pop_front();
          chk("done1_cyc", 32'(cyc), 32'(c));
        end
      end
    end
  end

  always @(negedge clk) begin : mon3
    ev_t e;
    int  c;
    if (mon_on) begin
      if (rd3) begin
        chk("rd3_expected", 32'(rq3.size() != 0), 32'd1);
        if (rq3.size() != 0) begin
          e = rq3.pop_front();
          chk("rd3_cyc", 32'(cyc), 32'(e.cyc));
          chk("rd3_a", 32'(ra3), 32'(e.a));
          chk("rd3_b", 32'(rb3), 32'(e.b));
          chk("rd3_k", 32'(tw3), 32'(e.k));
          chk("rd3_stage", 32'(st3), 32'(e.st));
        end
      end else chk("rd3_idle_zero", 32'({ra3, rb3, tw3}), 32'd0);
      if (bfv3) begin
        chk("bfv3_expected", 32'(bq3.size() != 0), 32'd1);
        if (bq3.size() != 0) begin
          c = bq3.pop_front();
          chk("bfv3_cyc", 32'(cyc), 32'(c));
        end
      end
      if (wr3) begin
        chk("wr3_expected", 32'(wq3.size() != 0), 32'd1);
        if (wq3.size() != 0) begin
          e = wq3.pop_front();
          chk("wr3_cyc", 32'(cyc), 32'(e.cyc));
          chk("wr3_a", 32'(wa3), 32'(e.a));
          chk("wr3_b", 32'(wb3), 32'(e.b));
        end
      end else chk("wr3_idle_zero", 32'({wa3, wb3}), 32'd0);
      if (done3) begin
        chk("done3_expected", 32'(dq3.size() != 0), 32'd1);
        chk("done3_busy", 32'(busy3), 32'd0);
        if (dq3.size() != 0) begin
          c = dq3.pop_front();
          chk("done3_cyc", 32'(cyc), 32'(c));
        end
      end
    end
  end

  initial begin
    int e;
    rst_n  = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;

    // Reset asserted mid-cycle clears all outputs immediately.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs_u1", 32'({busy1, done1, rd1, ra1, rb1, tw1, bfv1, st1, wr1, wa1, wb1}), 32'd0);
    chk("reset_outs_u3", 32'({busy3, done3, rd3, ra3, rb3, tw3, bfv3, st3, wr3, wa3, wb3}), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Idle with start low.
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("idle_u1", 32'({busy1, rd1, wr1, done1}), 32'd0);
      chk("idle_u3", 32'({busy3, rd3, wr3, done3}), 32'd0);
    end

    // Full run, BF_LAT=1.
    @(negedge clk);
    push_run(1, cyc + 1);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    directed(1, 21);

    // Full run, BF_LAT=3.
    @(negedge clk);
    push_run(3, cyc + 1);
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    directed(3, 27);

    // start held high: no retrigger while busy/DONE, second run after IDLE.
    @(negedge clk);
    e = cyc + 1;
    push_run(1, e);
    push_run(1, e + 20);
    start1 = 1'b1;
    for (int n = 1; n <= 25; n++) begin
      @(posedge clk);
      #1;
      if (n == 19) begin
        chk("held_c19_done", 32'(done1), 32'd1);
        chk("held_c19_busy", 32'(busy1), 32'd0);
      end
      if (n == 20) chk("held_c20_idle", 32'({busy1, rd1}), 32'd0);
      if (n == 21) begin
        chk("held_c21_rden", 32'(rd1), 32'd1);
        chk("held_c21_pair", 32'({ra1, rb1}), 32'({3'd0, 3'd1}));
      end
    end
    @(negedge clk);
    start1 = 1'b0;
    repeat (20) @(posedge clk);

    // Reset during stage 1 ISSUE drops in-flight work.
    @(negedge clk);
    push_run(1, cyc + 1);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 2; n <= 9; n++) @(posedge clk);
    #1;
    chk("c9_rden_before_rst", 32'(rd1), 32'd1);
    chk("c9_stage_before_rst", 32'(st1), 32'd1);
    chk("c9_wren_before_rst", 32'(wr1), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outs", 32'({busy1, wr1, bfv1, rd1, done1}), 32'd0);
    rq1.delete();
    wq1.delete();
    bq1.delete();
    dq1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);

    // Restart after reset begins at stage 0, pair (0,1).
    @(negedge clk);
    push_run(1, cyc + 1);
    start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    chk("restart_rden", 32'(rd1), 32'd1);
    chk("restart_stage", 32'(st1), 32'd0);
    chk("restart_pair", 32'({ra1, rb1}), 32'({3'd0, 3'd1}));
    repeat (22) @(posedge clk);
    #1;

    chk("left_rd1", 32'(rq1.size()), 32'd0);
    chk("left_wr1", 32'(wq1.size()), 32'd0);
    chk("left_bf1", 32'(bq1.size()), 32'd0);
    chk("left_done1", 32'(dq1.size()), 32'd0);
    chk("left_rd3", 32'(rq3.size()), 32'd0);
    chk("left_wr3", 32'(wq3.size()), 32'd0);
    chk("left_bf3", 32'(bq3.size()), 32'd0);
    chk("left_done3", 32'(dq3.size()), 32'd0);

    mon_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
